cascade_mod_counter: RTL and testbench

Multi-digit, runtime-programmable modulus counter. It is the parametrised successor of the single-stage fixed-modulus counter. It chains DIGITS stages of WIDTH bits each, all sharing one runtime modulus, with up/down count, synchronous load, enable, wrap or one-shot mode, and a terminal-count and carry interface for cascading. Typical uses are BCD time-of-day and event counters, clock dividers with a software-set ratio, and timeout timers in the control path.

---
 rtl/cascade_mod_counter.sv | 192 +++++++++++++++++++
 tb/tb_cascade_mod_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_mod_counter.sv
// -----------------------------------------------------------------------------
// cascade_mod_counter
//
// Multi-digit counter with one modulus shared by every digit. The modulus is
// programmable at runtime. DIGITS stages of WIDTH bits are chained with a
// ripple carry (up) or ripple borrow (down). The counter supports enable,
// synchronous load, and wrap or one-shot behaviour at the terminal value.
// Typical uses are BCD time/event counters, programmable clock dividers and
// timeout timers.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low (overrides load and enable)
//   en_i         count enable, one step per cycle while high
//   up_i         direction: 1 = increment, 0 = decrement
//   oneshot_i    1 = stop at the terminal value and flag done, 0 = wrap
//   mod_m1_i     per-stage modulus minus one (each stage counts 0..mod_m1_i)
//   load_i       synchronous load strobe (has priority over en_i)
//   load_val_i   load value, stage i in bits [i*WIDTH +: WIDTH]
//   count_o      current value, stage 0 least significant
//   tc_o         terminal count, combinational from count, up_i and mod_m1_i
//   carry_out_o  registered one-cycle pulse in the cycle that shows a wrap
//   done_o       registered sticky flag, set on reaching terminal in one-shot
// -----------------------------------------------------------------------------
module cascade_mod_counter #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic                      up_i,
   input  logic                      oneshot_i,
   input  logic [WIDTH-1:0]          mod_m1_i,
   input  logic                      load_i,
   input  logic [DIGITS*WIDTH-1:0]   load_val_i,
   output logic [DIGITS*WIDTH-1:0]   count_o,
   output logic                      tc_o,
   output logic                      carry_out_o,
   output logic                      done_o
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   // ------------------------------------------------------------------------
   // Per-stage helpers
   // ------------------------------------------------------------------------

   // A stage is terminal when it would pass a carry/borrow to the next stage.
   // When counting up, a stage above the modulus also counts as terminal, so a
   // stage left out of range by a modulus change rolls over on its next step.
   function automatic logic stage_terminal(input logic [WIDTH-1:0] v,
                                           input logic [WIDTH-1:0] m,
                                           input logic             up);
      logic t;
      if (up) begin
         t = (v >= m);
      end else begin
         t = (v == ZERO);
      end
      return t;
   endfunction

   // Increment with rollover. The >= test also resolves out-of-range stages.
   function automatic logic [WIDTH-1:0] stage_inc(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] m);
      logic [WIDTH-1:0] r;
      if (v >= m) begin
         r = ZERO;
      end else begin
         r = v + ONE;
      end
      return r;
   endfunction

   // Decrement with underflow to the modulus. An out-of-range stage snaps to
   // the modulus. It is not zero, so it was never terminal and lends no borrow.
   function automatic logic [WIDTH-1:0] stage_dec(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] m);
      logic [WIDTH-1:0] r;
      if (v == ZERO) begin
         r = m;
      end else if (v > m) begin
         r = m;
      end else begin
         r = v - ONE;
      end
      return r;
   endfunction

   // Limit a loaded stage value to the current modulus.
   function automatic logic [WIDTH-1:0] stage_clamp(input logic [WIDTH-1:0] v,
                                                    input logic [WIDTH-1:0] m);
      logic [WIDTH-1:0] r;
      if (v > m) begin
         r = m;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DIGITS-1:0][WIDTH-1:0] count_q;
   logic [DIGITS-1:0][WIDTH-1:0] count_d;
   logic                         carry_q;
   logic                         carry_d;
   logic                         done_q;
   logic                         done_d;

   // Datapath intermediates
   logic [DIGITS-1:0]            term_s;
   logic [DIGITS-1:0]            step_s;
   logic [DIGITS-1:0][WIDTH-1:0] stepped_s;
   logic [DIGITS-1:0][WIDTH-1:0] loaded_s;
   logic                         ripple_s;
   logic                         tc_s;

   // Per-stage terminal flags, the ripple step mask, and candidate values.
   always_comb begin
      ripple_s  = 1'b1;
      term_s    = {DIGITS{1'b0}};
      step_s    = {DIGITS{1'b0}};
      stepped_s = {(DIGITS*WIDTH){1'b0}};
      loaded_s  = {(DIGITS*WIDTH){1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         term_s[i] = stage_terminal(count_q[i], mod_m1_i, up_i);
         // Stage i steps only when every lower stage is terminal.
         step_s[i] = ripple_s;
         ripple_s  = ripple_s & term_s[i];
         if (up_i) begin
            stepped_s[i] = stage_inc(count_q[i], mod_m1_i);
         end else begin
            stepped_s[i] = stage_dec(count_q[i], mod_m1_i);
         end
         loaded_s[i] = stage_clamp(load_val_i[i*WIDTH +: WIDTH], mod_m1_i);
      end
   end

   assign tc_s = &term_s;

   // Next-state selection, in priority order: load, then enabled step, then hold.
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      done_d  = done_q;
      if (load_i) begin
         count_d = loaded_s;
         done_d  = 1'b0;
      end else if (en_i) begin
         if (tc_s && oneshot_i) begin
            // One-shot: freeze at the terminal value and latch done.
            count_d = count_q;
            done_d  = 1'b1;
         end else begin
            for (int i = 0; i < DIGITS; i++) begin
               if (step_s[i]) begin
                  count_d[i] = stepped_s[i];
               end else begin
                  count_d[i] = count_q[i];
               end
            end
            // When tc is set here, every stage wraps. oneshot_i is low on this path.
            carry_d = tc_s;
         end
      end else begin
         count_d = count_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= {(DIGITS*WIDTH){1'b0}};
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign count_o     = count_q;
   assign tc_o        = tc_s;
   assign carry_out_o = carry_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_cascade_mod_counter
//
// The bench runs directed scenarios followed by randomized stimulus for a
// 2-digit, 4-bit cascade_mod_counter. The driver updates a digit-array
// reference model and queues the expected tc for the current cycle and the
// expected registered state for the next cycle. A separate monitor compares
// DUT outputs against these queues on every falling edge.
// -----------------------------------------------------------------------------
module tb_cascade_mod_counter;

   localparam int D  = 2;
   localparam int W  = 4;
   localparam int CW = D * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          up;
   logic          oneshot;
   logic [W-1:0]  mod_m1;
   logic          load;
   logic [CW-1:0] load_val;
   logic [CW-1:0] count;
   logic          tc;
   logic          carry_out;
   logic          done;

   cascade_mod_counter #(.DIGITS(D), .WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en),
      .up_i        (up),
      .oneshot_i   (oneshot),
      .mod_m1_i    (mod_m1),
      .load_i      (load),
      .load_val_i  (load_val),
      .count_o     (count),
      .tc_o        (tc),
      .carry_out_o (carry_out),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [CW-1:0] count;
      logic          carry;
      logic          done;
   } st_exp_t;

   typedef struct {
      int   cyc;
      logic tc;
   } tc_exp_t;

   st_exp_t st_q[$];
   tc_exp_t tc_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model: digit values as plain integers.
   int md[D];
   bit mcarry;
   bit mdone;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // The count is terminal when no digit can absorb another step.
   function automatic bit model_tc(input bit u, input int m);
      bit t;
      t = 1'b1;
      for (int i = 0; i < D; i++) begin
         if (u ? (md[i] < m) : (md[i] != 0)) t = 1'b0;
      end
      return t;
   endfunction

   function automatic logic [CW-1:0] model_count();
      logic [CW-1:0] v;
      v = '0;
      for (int i = 0; i < D; i++) v[i*W +: W] = W'(md[i]);
      return v;
   endfunction

   task automatic model_advance(input bit r, input bit e, input bit u, input bit os,
                                input int m, input bit l, input logic [CW-1:0] lv);
      bit t;
      bit c;
      int dv;
      if (!r) begin
         for (int i = 0; i < D; i++) md[i] = 0;
         mcarry = 1'b0;
         mdone  = 1'b0;
      end else if (l) begin
         for (int i = 0; i < D; i++) begin
            dv    = int'(lv[i*W +: W]);
            md[i] = (dv > m) ? m : dv;
         end
         mdone  = 1'b0;
         mcarry = 1'b0;
      end else if (e) begin
         t = model_tc(u, m);
         if (t && os) begin
            mdone  = 1'b1;
            mcarry = 1'b0;
         end else begin
            // Add or subtract one digit by digit, least significant first.
            c = 1'b1;
            for (int i = 0; i < D; i++) begin
               if (c) begin
                  if (u) begin
                     if (md[i] >= m) md[i] = 0;
                     else begin md[i] = md[i] + 1; c = 1'b0; end
                  end else begin
                     if (md[i] == 0) md[i] = m;
                     else if (md[i] > m) begin md[i] = m; c = 1'b0; end
                     else begin md[i] = md[i] - 1; c = 1'b0; end
                  end
               end
            end
            mcarry = t;
         end
      end else begin
         mcarry = 1'b0;
      end
   endtask

   // Drive one cycle of inputs and queue the expected responses.
   task automatic drive(input bit r, input bit e, input bit u, input bit os,
                        input logic [W-1:0] m, input bit l, input logic [CW-1:0] lv);
      tc_exp_t te;
      st_exp_t se;
      @(posedge clk);
      #1;
      rst = r; en = e; up = u; oneshot = os; mod_m1 = m; load = l; load_val = lv;
      te.cyc = cyc;
      te.tc  = model_tc(u, int'(m));
      tc_q.push_back(te);
      model_advance(r, e, u, os, int'(m), l, lv);
      se.cyc   = cyc + 1;
      se.count = model_count();
      se.carry = mcarry;
      se.done  = mdone;
      st_q.push_back(se);
   endtask

   // Monitor: compare DUT outputs with queued expectations on each falling edge.
   initial begin
      tc_exp_t te;
      st_exp_t se;
      forever begin
         @(negedge clk);
         while (tc_q.size() > 0 && tc_q[0].cyc <= cyc) begin
            te = tc_q.pop_front();
            chk("tc", 32'(tc), 32'(te.tc));
         end
         while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            se = st_q.pop_front();
            chk("count", 32'(count), 32'(se.count));
            chk("carry_out", 32'(carry_out), 32'(se.carry));
            chk("done", 32'(done), 32'(se.done));
         end
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      st_exp_t    s0;
      bit         ru;
      bit         ros;
      logic [W-1:0] rm;
      rst = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0; mod_m1 = 4'd9;
      load = 1'b0; load_val = 8'h00;
      for (int i = 0; i < D; i++) md[i] = 0;
      mcarry = 1'b0; mdone = 1'b0;
      s0.cyc = 1; s0.count = 8'h00; s0.carry = 1'b0; s0.done = 1'b0;
      st_q.push_back(s0);

      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);
      // BCD up count through a full wrap and beyond
      for (int i = 0; i < 205; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);
      // Down count from reset
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 8'h00);
      for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 8'h00);
      // Load with clamping, load wins over enable
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 8'hC3);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);
      // One-shot stop and done clear by load
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 8'h97);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 8'h10);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);
      // Modulus shrink with out-of-range stages
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 8'h75);
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 8'h00);
      // Down with out-of-range stages
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 8'h97);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 8'h00);
      // Reset with a carry about to be produced
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 8'h99);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);

      // Randomized operation
      ru = 1'b1; ros = 1'b0; rm = 4'd9;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) ru  = ~ru;
         if ($urandom_range(0, 31) == 0) ros = ~ros;
         if ($urandom_range(0, 39) == 0) rm  = 4'($urandom_range(0, 15));
         drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), ru, ros, rm,
               ($urandom_range(0, 15) == 0), 8'($urandom));
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 8'h00);

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("queues_drained", 32'(st_q.size() + tc_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
